// File: rtl/sobel_pkg.sv
// Shared defaults and FSM encoding for the Sobel frame sequencer.
// Imported by the scheduler top and its testbench.
package sobel_pkg;

  localparam int DEF_IMG_W    = 256;
  localparam int DEF_IMG_H    = 256;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_PIPE_LAT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sobel_frame_scheduler_delay.sv
// Write-back delay line: shifts {valid, border, addr} so each output-RAM
// write lines up with the datapath result for the same pixel.
module sobel_wb_delay #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_border,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic              o_border,
  output logic [ADDR_W-1:0] o_addr
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_border;
  logic [ADDR_W-1:0] r_addr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_border <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_addr[i] <= '0;
    end else begin
      r_valid[0]  <= i_valid;
      r_border[0] <= i_border;
      r_addr[0]   <= i_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i]  <= r_valid[i-1];
        r_border[i] <= r_border[i-1];
        r_addr[i]   <= r_addr[i-1];
      end
    end
  end

  assign o_valid  = r_valid[DEPTH-1];
  assign o_border = r_border[DEPTH-1];
  assign o_addr   = r_addr[DEPTH-1];

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Frame sequencer: raster-scans the loaded image issuing window reads,
// then writes each result (or a zero border pixel) to the output RAM.
module sobel_frame_scheduler
  import sobel_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              transfer_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_border,
  output logic              busy,
  output logic              processing_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int DR_W  = $clog2(PIPE_LAT + 2);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LAT);

  sched_state_t r_state;
  sched_state_t w_next;

  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;
  logic [DR_W-1:0]   r_drain;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_done;

  logic w_col_end;
  logic w_last;
  logic w_border;

  assign w_col_end = (r_col == COL_LAST);
  assign w_last    = w_col_end && (r_row == ROW_LAST);
  assign w_border  = (r_row == '0) || (r_row == ROW_LAST) ||
                     (r_col == '0) || w_col_end;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (transfer_done)     w_next = S_SCAN;
      S_SCAN:  if (w_last)            w_next = S_DRAIN;
      S_DRAIN: if (r_drain == DR_LAST) w_next = S_DONE;
      S_DONE:  if (!transfer_done)    w_next = S_IDLE;
      default:                        w_next = S_IDLE;
    endcase
  end

  // Counters rest at zero outside SCAN so each frame starts at pixel 0.
  always_ff @(posedge clk) begin
    if (rst || r_state != S_SCAN || w_last) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_DRAIN) r_drain <= '0;
    else                           r_drain <= r_drain + DR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= (w_next == S_SCAN);
      r_busy  <= (w_next == S_SCAN) || (w_next == S_DRAIN);
      r_done  <= (w_next == S_DONE);
    end
  end

  sobel_wb_delay #(
    .DEPTH  (PIPE_LAT + 1),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (r_rd_en),
    .i_border (r_rd_en & w_border),
    .i_addr   (r_rd_en ? r_addr : '0),
    .o_valid  (wr_en),
    .o_border (wr_border),
    .o_addr   (wr_addr)
  );

  assign rd_en           = r_rd_en;
  assign rd_addr         = r_addr;
  assign busy            = r_busy;
  assign processing_done = r_done;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed + randomized bench for sobel_frame_scheduler on a 4x4 frame
// and a full 256x256 frame, checked against an arithmetic frame model.
module tb_sobel_frame_scheduler;
  import sobel_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst, td;
  logic rd_en, wr_en, wr_border, busy, pdone;
  logic [15:0] rd_addr, wr_addr;

  logic rst_b, td_b;
  logic rd_en_b, wr_en_b, wr_border_b, busy_b, pdone_b;
  logic [15:0] rd_addr_b, wr_addr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_frame_scheduler #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(16), .PIPE_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .transfer_done(td),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_border(wr_border),
    .busy(busy), .processing_done(pdone)
  );

  sobel_frame_scheduler #(
    .IMG_W(256), .IMG_H(256), .ADDR_W(16), .PIPE_LAT(2)
  ) dut_big (
    .clk(clk), .rst(rst_b), .transfer_done(td_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_border(wr_border_b),
    .busy(busy_b), .processing_done(pdone_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_border(input int a);
    int r, c;
    r = a / W;
    c = a % W;
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 0);
    chk({tag, "_rd_addr"}, {16'd0, rd_addr}, 0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 0);
    chk({tag, "_wr_addr"}, {16'd0, wr_addr}, 0);
    chk({tag, "_wr_border"}, {31'd0, wr_border}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, pdone}, {31'd0, exp_done});
  endtask

  // Expected outputs k cycles after the frame's first read.
  task automatic chk_frame_cycle(input int k, input bit td_prev);
    bit e_rd, e_wr, e_wb, e_busy, e_done;
    int e_ra, e_wa;
    e_rd   = (k < N);
    e_ra   = e_rd ? k : 0;
    e_wr   = (k >= L) && (k < L + N);
    e_wa   = e_wr ? k - L : 0;
    e_wb   = e_wr && is_border(k - L);
    e_busy = (k < N + L);
    e_done = (k == N + L) || (k > N + L && td_prev);
    chk($sformatf("rd_en@%0d", k), {31'd0, rd_en}, {31'd0, e_rd});
    chk($sformatf("rd_addr@%0d", k), {16'd0, rd_addr}, e_ra);
    chk($sformatf("wr_en@%0d", k), {31'd0, wr_en}, {31'd0, e_wr});
    chk($sformatf("wr_addr@%0d", k), {16'd0, wr_addr}, e_wa);
    chk($sformatf("wr_border@%0d", k), {31'd0, wr_border}, {31'd0, e_wb});
    chk($sformatf("busy@%0d", k), {31'd0, busy}, {31'd0, e_busy});
    chk($sformatf("done@%0d", k), {31'd0, pdone}, {31'd0, e_done});
  endtask

  task automatic run_frame(input int drop_at, input int hold);
    bit td_prev;
    td = 1'b1;
    td_prev = 1'b1;
    for (int k = 0; k < N + L + hold; k++) begin
      @(negedge clk);
      chk_frame_cycle(k, td_prev);
      if (k == drop_at) td = 1'b0;
      td_prev = td;
    end
    td = 1'b0;
    @(negedge clk);
    chk_idle("after_frame", 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_idle("idle", 1'b0);
    end
  endtask

  initial begin
    int wcount, rcount, interior, last_wa, cyc;
    bit order_ok;
    rst = 1'b1; td = 1'b0;
    rst_b = 1'b1; td_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    idle_cycles(10);

    run_frame(-1, 20);
    idle_cycles($urandom_range(1, 5));
    run_frame(-1, $urandom_range(2, 12));
    idle_cycles($urandom_range(1, 5));
    run_frame($urandom_range(0, N + L - 1), 4);
    idle_cycles($urandom_range(1, 5));

    td = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk_frame_cycle(k, 1'b1);
    end
    rst = 1'b1; td = 1'b0;
    @(negedge clk);
    chk_idle("post_rst", 1'b0);
    rst = 1'b0;
    idle_cycles(10);
    run_frame(-1, 3);

    td_b = 1'b1;
    wcount = 0; rcount = 0; interior = 0; last_wa = -1;
    order_ok = 1'b1;
    cyc = 0;
    while (cyc < 70000 && !pdone_b) begin
      @(negedge clk);
      cyc++;
      if (rd_en_b) rcount++;
      if (wr_en_b) begin
        if (int'(wr_addr_b) != wcount) order_ok = 1'b0;
        if (!wr_border_b) interior++;
        last_wa = int'(wr_addr_b);
        wcount++;
      end
    end
    chk("big_finished", {31'd0, pdone_b}, 1);
    chk("big_reads", rcount, 65536);
    chk("big_writes", wcount, 65536);
    chk("big_interior", interior, 254 * 254);
    chk("big_last_addr", last_wa, 32'hFFFF);
    chk("big_raster_order", {31'd0, order_ok}, 1);
    td_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
